rpn_sequencer: RTL

Program sequencer that sits directly upstream of the stack arithmetic unit and drives its push/en/d/op inputs. It holds a small program memory of 19-bit instructions, which is loaded while idle. On start it steps through the program, issuing one stack command per instruction. Between commands it checks conditional jumps against the unit's top-of-stack and guards against stack underflow and overflow using the unit's depth count.

---
 rtl/rpn_pkg.sv | 63 ++++++
 rtl/rpn_prog_mem.sv | 32 +++
 rtl/rpn_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN program sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Instruction word: [18:16] kind, [15:0] payload.
package rpn_pkg;

    localparam int INSTR_W = 19;
    localparam int DATA_W  = 16;
    localparam int OP_W    = 3;
    localparam int CNT_W   = 10;

    // Deepest the downstream stack can get; a push at this depth overflows.
    localparam logic [CNT_W-1:0] STK_MAX = 10'd1023;

    typedef enum logic [2:0] {
        K_PUSH = 3'd0,
        K_OP   = 3'd1,
        K_JMP  = 3'd2,
        K_JZ   = 3'd3,
        K_JNZ  = 3'd4,
        K_HALT = 3'd5,
        K_RSV6 = 3'd6,
        K_RSV7 = 3'd7
    } kind_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_UNDER = 2'd1,
        ERR_OVER  = 2'd2,
        ERR_WDOG  = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_SETTLE,
        S_DONE
    } state_t;

    // Stack unit opcodes.
    localparam logic [OP_W-1:0] OP_POS  = 3'd0;
    localparam logic [OP_W-1:0] OP_NEG  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd4;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd5;
    localparam logic [OP_W-1:0] OP_POP6 = 3'd6;
    localparam logic [OP_W-1:0] OP_POP7 = 3'd7;

    // Minimum stack depth an opcode needs before it may be issued.
    function automatic logic [CNT_W-1:0] need_depth(input logic [OP_W-1:0] op);
        case (op)
            OP_POS:                          need_depth = 10'd0;
            OP_ADD, OP_SUB, OP_MUL:          need_depth = 10'd2;
            OP_NEG, OP_LOAD, OP_POP6, OP_POP7: need_depth = 10'd1;
            default:                         need_depth = 10'd1;
        endcase
    endfunction

endpackage

// File: rtl/rpn_prog_mem.sv
// Program RAM: 2^AW x 19, one write port, one synchronous read port.
// Latency: read data valid the cycle after i_re.
// Backpressure: none; writes and reads always accepted.
//
// Ports: i_we/i_waddr/i_wdata write; i_re/i_raddr -> o_rdata read.
// Contents are deliberately not reset so a program survives nrst.
module rpn_prog_mem
    import rpn_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/rpn_sequencer.sv
// Program sequencer driving a stack arithmetic unit's push/en/d/op.
// Latency: PUSH/OP 4 cycles, jumps 2 cycles, HALT reaches done 2 cycles after fetch.
// Backpressure: none; the unit is assumed to accept one command per ISSUE cycle.
//
// Ports: prog_we/prog_addr/prog_data load program (idle only); start runs from pc 0;
// stk_top/stk_cnt observe the unit; stk_* command it; busy/done/err/err_code/pc status.
// Optional: RPN_SEQ_WATCHDOG_EN enables a MAX_STEPS instruction budget (err_code 3).
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int PROG_AW   = 10,
    parameter int MAX_STEPS = 65535
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic [DATA_W-1:0]  stk_top,
    input  logic [CNT_W-1:0]   stk_cnt,
    output logic               stk_push,
    output logic               stk_en,
    output logic [DATA_W-1:0]  stk_d,
    output logic [OP_W-1:0]    stk_op,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [PROG_AW-1:0] pc
);

    state_t               r_state, w_next;
    logic [PROG_AW-1:0]   r_pc, w_pc_next, w_target, w_pc_inc;
    logic                 r_stk_push, r_stk_en, r_err;
    logic [DATA_W-1:0]    r_stk_d;
    logic [OP_W-1:0]      r_stk_op;
    err_t                 r_err_code, w_code;
    logic [INSTR_W-1:0]   w_instr;
    kind_t                w_kind;
    logic [DATA_W-1:0]    w_payload;
    logic                 w_busy, w_start_acc, w_under, w_over, w_wdog;
    logic                 w_fault, w_issue;

    assign w_busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                         (r_state == S_ISSUE) || (r_state == S_SETTLE);
    assign w_start_acc = start && !w_busy;

    // Write lands on the same edge that accepts start, so the first fetch sees it.
    rpn_prog_mem #(.AW(PROG_AW)) u_mem (
        .clk     (clk),
        .i_we    (prog_we && !w_busy),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_re    (r_state == S_FETCH),
        .i_raddr (r_pc),
        .o_rdata (w_instr)
    );

    assign w_kind    = kind_t'(w_instr[INSTR_W-1:DATA_W]);
    assign w_payload = w_instr[DATA_W-1:0];
    assign w_target  = w_payload[PROG_AW-1:0];
    assign w_pc_inc  = r_pc + PROG_AW'(1);

    assign w_under = (w_kind == K_OP)   && (stk_cnt < need_depth(w_payload[OP_W-1:0]));
    assign w_over  = (w_kind == K_PUSH) && (stk_cnt == STK_MAX);

`ifdef RPN_SEQ_WATCHDOG_EN
    logic [31:0] r_steps;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_steps <= '0;
        end else if (w_start_acc) begin
            r_steps <= '0;
        end else if (r_state == S_DECODE) begin
            r_steps <= r_steps + 32'd1;
        end
    end

    // Trips on the MAX_STEPS-th DECODE, before that instruction takes effect.
    assign w_wdog = (r_state == S_DECODE) && (r_steps == 32'(MAX_STEPS - 1));
`else
    logic w_unused_max_steps;
    assign w_unused_max_steps = (MAX_STEPS != 0);
    assign w_wdog = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_fault   = 1'b0;
        w_code    = ERR_NONE;
        w_issue   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                // Guards leave pc on the faulting instruction.
                if (w_wdog) begin
                    w_next  = S_DONE;
                    w_fault = 1'b1;
                    w_code  = ERR_WDOG;
                end else if (w_under) begin
                    w_next  = S_DONE;
                    w_fault = 1'b1;
                    w_code  = ERR_UNDER;
                end else if (w_over) begin
                    w_next  = S_DONE;
                    w_fault = 1'b1;
                    w_code  = ERR_OVER;
                end else begin
                    case (w_kind)
                        K_PUSH, K_OP: begin
                            w_issue   = 1'b1;
                            w_pc_next = w_pc_inc;
                            w_next    = S_ISSUE;
                        end
                        K_JMP: begin
                            w_pc_next = w_target;
                            w_next    = S_FETCH;
                        end
                        K_JZ: begin
                            w_pc_next = (stk_top == '0) ? w_target : w_pc_inc;
                            w_next    = S_FETCH;
                        end
                        K_JNZ: begin
                            w_pc_next = (stk_top != '0) ? w_target : w_pc_inc;
                            w_next    = S_FETCH;
                        end
                        default: w_next = S_DONE;
                    endcase
                end
            end
            S_ISSUE:  w_next = S_SETTLE;
            S_SETTLE: w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pc       <= '0;
            r_stk_en   <= 1'b0;
            r_stk_push <= 1'b0;
            r_stk_d    <= '0;
            r_stk_op   <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_pc       <= w_start_acc ? '0 : w_pc_next;
            // stk_en is high only in ISSUE because w_issue always leads to ISSUE.
            r_stk_en   <= w_issue;
            r_stk_push <= w_issue && (w_kind == K_PUSH);
            if (w_issue) begin
                if (w_kind == K_PUSH) begin
                    r_stk_d  <= w_payload;
                    r_stk_op <= OP_POS;
                end else begin
                    r_stk_d  <= '0;
                    r_stk_op <= w_payload[OP_W-1:0];
                end
            end
            if (w_start_acc) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end else if (w_fault) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end
        end
    end

    assign stk_push = r_stk_push;
    assign stk_en   = r_stk_en;
    assign stk_d    = r_stk_d;
    assign stk_op   = r_stk_op;
    assign busy     = w_busy;
    assign done     = (r_state == S_DONE);
    assign err      = r_err;
    assign err_code = r_err_code;
    assign pc       = r_pc;

endmodule
